// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues the request-to-send,
// shifts out data/parity/stop on device clock edges and checks the device ACK.
//
// state        | meaning
// IDLE         | lines released, ready for a command byte
// INHIBIT      | clock held low to abort any device activity
// START        | clock and data both low (start bit / request)
// SHIFT        | clock released, one frame bit presented per device falling edge
// WAIT_ACK     | stop bit sent, sampling device ACK on the next falling edge
// WAIT_RELEASE | ACK seen, waiting for the device to release both lines
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_CYCLES   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] INHIBIT      = 3'd1;
    localparam logic [2:0] START        = 3'd2;
    localparam logic [2:0] SHIFT        = 3'd3;
    localparam logic [2:0] WAIT_ACK     = 3'd4;
    localparam logic [2:0] WAIT_RELEASE = 3'd5;

    // Down-counters are loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LOAD   = 20'(START_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LOAD = 20'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [19:0] cnt;
    logic [3:0]  bit_idx;
    logic [9:0]  frame;
    logic        clk_meta;
    logic        clk_sync;
    logic        clk_prev;
    logic        data_meta;
    logic        data_sync;
    logic        clk_oe_q;
    logic        data_oe_q;
    logic        done_q;
    logic        err_q;
    logic        clk_fall;
    logic        watched;
    logic        timeout;

    assign clk_fall = clk_prev & ~clk_sync;
    assign watched  = (state == SHIFT) || (state == WAIT_ACK) || (state == WAIT_RELEASE);
    assign timeout  = watched && (cnt == 20'd0);

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 20'd0;
            bit_idx   <= 4'd0;
            frame     <= 10'd0;
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            // Watchdog abort wins over any edge seen in the same cycle.
            if (timeout) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                err_q     <= 1'b1;
                cnt       <= 20'd0;
                bit_idx   <= 4'd0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            frame     <= {1'b1, ~^tx_data, tx_data};
                            cnt       <= INHIBIT_LOAD;
                            bit_idx   <= 4'd0;
                            clk_oe_q  <= 1'b1;
                            data_oe_q <= 1'b0;
                            state     <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == 20'd0) begin
                            cnt       <= START_LOAD;
                            data_oe_q <= 1'b1;
                            state     <= START;
                        end else begin
                            cnt <= cnt - 20'd1;
                        end
                    end
                    START: begin
                        if (cnt == 20'd0) begin
                            clk_oe_q <= 1'b0;
                            cnt      <= TIMEOUT_LOAD;
                            bit_idx  <= 4'd0;
                            state    <= SHIFT;
                        end else begin
                            cnt <= cnt - 20'd1;
                        end
                    end
                    SHIFT: begin
                        cnt <= cnt - 20'd1;
                        if (clk_fall) begin
                            data_oe_q <= ~frame[bit_idx];
                            bit_idx   <= bit_idx + 4'd1;
                            if (bit_idx == 4'd9) begin
                                state <= WAIT_ACK;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        cnt <= cnt - 20'd1;
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state <= WAIT_RELEASE;
                            end else begin
                                err_q   <= 1'b1;
                                bit_idx <= 4'd0;
                                cnt     <= 20'd0;
                                state   <= IDLE;
                            end
                        end
                    end
                    WAIT_RELEASE: begin
                        cnt <= cnt - 20'd1;
                        if (clk_sync && data_sync) begin
                            done_q  <= 1'b1;
                            bit_idx <= 4'd0;
                            cnt     <= 20'd0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        cnt       <= 20'd0;
                        bit_idx   <= 4'd0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a simple PS/2 device model clocks frames at one
// falling edge per 40 system cycles and ACKs, NAKs or stays silent as each step requires.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int n_both  = 0;
    int n_long  = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    logic ready_after_err = 1'b0;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .START_CYCLES  (4),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done = n_done + 1;
        if (tx_err) n_err = n_err + 1;
        if (tx_done && tx_err) n_both = n_both + 1;
        if ((tx_done && prev_done) || (tx_err && prev_err)) n_long = n_long + 1;
        if (prev_err) ready_after_err = tx_ready;
        prev_done = tx_done;
        prev_err  = tx_err;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requests a byte and measures how long clock and data are held low before release.
    task automatic send(input logic [7:0] b, input logic glitch, output int n_clk, output int n_data);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n_clk  = 0;
        n_data = 0;
        while (ps2_clk_oe && n_clk < 200) begin
            n_clk = n_clk + 1;
            if (ps2_data_oe) n_data = n_data + 1;
            if (glitch && n_clk == 5) begin
                tx_valid = 1'b1;
                tx_data  = 8'h12;
            end
            if (glitch && n_clk == 7) tx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic dev_edge(output logic oe);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        oe = ps2_data_oe;
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic dev_bits(input logic [9:0] exp, input int n, input string tag);
        logic oe;
        repeat (10) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            dev_edge(oe);
            check($sformatf("%s_edge%0d", tag, k + 1), 32'(oe), 32'(exp[k]));
        end
    endtask

    task automatic dev_ack(input logic ack);
        logic oe;
        if (ack) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_edge(oe);
        dev_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [9:0] exp, input logic ack,
                             input logic glitch, input string tag);
        int nc;
        int nd;
        int d0;
        int e0;
        d0 = n_done;
        e0 = n_err;
        send(b, glitch, nc, nd);
        check({tag, "_clk_low_cycles"}, 32'(nc), 32'd24);
        check({tag, "_data_low_cycles"}, 32'(nd), 32'd4);
        dev_bits(exp, 10, tag);
        dev_ack(ack);
        check({tag, "_done_count"}, 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_count"}, 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check({tag, "_ready_end"}, 32'(tx_ready), 32'd1);
        check({tag, "_lines_end"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    endtask

    initial begin
        int nc;
        int nd;
        int d0;
        int e0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", 32'({tx_done, tx_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 32'd1);

        // 0xED: data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 -> inverted on data_oe
        run_frame(8'hED, 10'b0000010010, 1'b1, 1'b0, "ed_ack");
        run_frame(8'h00, 10'b0011111111, 1'b1, 1'b0, "zero_ack");

        run_frame(8'h55, 10'b0010101010, 1'b0, 1'b0, "nak_55");
        check("nak_ready_next_cycle", 32'(ready_after_err), 32'd1);

        // Silent device: watchdog fires 2000 cycles after clock release.
        e0 = n_err;
        d0 = n_done;
        send(8'hF4, 1'b0, nc, nd);
        check("timeout_clk_low_cycles", 32'(nc), 32'd24);
        repeat (1999) @(negedge clk);
        check("timeout_err_early", 32'(tx_err), 32'd0);
        @(negedge clk);
        check("timeout_err_pulse", 32'(tx_err), 32'd1);
        check("timeout_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        @(negedge clk);
        check("timeout_err_width", 32'(tx_err), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_counts", 32'({n_done - d0, n_err - e0}), 32'(64'd1));

        // Reset mid-frame after edge 4.
        e0 = n_err;
        d0 = n_done;
        send(8'hED, 1'b0, nc, nd);
        dev_bits(10'b0000010010, 4, "rst_ed");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("midrst_no_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        run_frame(8'hFF, 10'b0000000000, 1'b1, 1'b0, "ff_after_rst");

        // A second request during a frame is dropped, and tx_data changes do not leak in.
        run_frame(8'hED, 10'b0000010010, 1'b1, 1'b1, "ed_glitch");
        repeat (5) @(negedge clk);
        check("glitch_not_queued", 32'(busy), 32'd0);

        check("done_err_overlap", 32'(n_both), 32'd0);
        check("pulse_width", 32'(n_long), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
